// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//
// Purpose:
//   Shares one adder datapath between NUM_REQ requesters. In IDLE a
//   round-robin arbiter accepts one operand pair, latches it and records the
//   requester ID in an order FIFO. In ISSUE the latched operands are offered
//   on the adder's A and B channels, and each channel is held until it
//   handshakes. The adder returns results in order. The result at the head of
//   the adder output is routed back to the requester whose ID is at the head
//   of the order FIFO.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_a_i, req_b_i        packed per-requester operands (slice r = requester r)
//   req_valid_i/req_ready_o per-requester operand-pair handshake (ready one-hot)
//   rsp_data_o              shared result bus (the adder's out, passed through)
//   rsp_valid_o/rsp_ready_i per-requester result handshake (valid one-hot)
//   inA/inA_valid/inA_ready adder operand A channel
//   inB/inB_valid/inB_ready adder operand B channel
//   out/out_valid/out_ready adder result channel
//   err_o                   sticky: a result arrived with nothing outstanding
module adder_share_arbiter #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int NUM_REQ       = 2,
  parameter int TAG_DEPTH     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [DATA_IN_WIDTH:0]             rsp_data_o,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic [DATA_IN_WIDTH-1:0]           inA,
  output logic [DATA_IN_WIDTH-1:0]           inB,
  output logic                               inA_valid,
  output logic                               inB_valid,
  input  logic                               inA_ready,
  input  logic                               inB_ready,
  input  logic [DATA_IN_WIDTH:0]             out,
  input  logic                               out_valid,
  output logic                               out_ready,
  output logic                               err_o
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } stateType;

  // ---------------------------------------------------------------------
  // Unpack the per-requester operand slices
  // ---------------------------------------------------------------------
  logic [DATA_IN_WIDTH-1:0] reqA [NUM_REQ];
  logic [DATA_IN_WIDTH-1:0] reqB [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqA[gi] = req_a_i[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH];
      assign reqB[gi] = req_b_i[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  stateType                 stateReg, stateNext;
  logic [ID_W-1:0]          ptrReg, ptrNext;
  logic [DATA_IN_WIDTH-1:0] aQReg, aQNext;
  logic [DATA_IN_WIDTH-1:0] bQReg, bQNext;
  logic                     aDoneReg, aDoneNext;
  logic                     bDoneReg, bDoneNext;
  logic                     errReg;

  // Order FIFO of requester IDs
  logic [ID_W-1:0]  fifoMem [TAG_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic [ID_W-1:0]  headId;
  logic             fifoEmpty, fifoFull;

  // ---------------------------------------------------------------------
  // Round-robin pick: the valid requester with the smallest upward
  // distance from ptrReg (wrapping) wins.
  // ---------------------------------------------------------------------
  logic            grantFound;
  logic [ID_W-1:0] grantIdx;
  logic            grant;
  int              pickDist;
  int              pickBest;

  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    pickDist   = 0;
    pickBest   = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      pickDist = (j >= int'(ptrReg)) ? (j - int'(ptrReg))
                                     : (j + NUM_REQ - int'(ptrReg));
      if (req_valid_i[j] && (pickDist < pickBest)) begin
        pickBest   = pickDist;
        grantIdx   = ID_W'(j);
        grantFound = 1'b1;
      end
    end
  end

  // The full check uses the registered count, so a pop in the same cycle
  // does not open a slot until the following cycle.
  assign grant = (stateReg == IDLE) && !rst_i && grantFound && !fifoFull;

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grantIdx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM: next state and channel valids
  // ---------------------------------------------------------------------
  logic aHandshake, bHandshake;

  always_comb begin
    stateNext  = stateReg;
    ptrNext    = ptrReg;
    aQNext     = aQReg;
    bQNext     = bQReg;
    aDoneNext  = aDoneReg;
    bDoneNext  = bDoneReg;
    inA_valid  = 1'b0;
    inB_valid  = 1'b0;
    aHandshake = 1'b0;
    bHandshake = 1'b0;

    case (stateReg)
      IDLE: begin
        if (grant) begin
          aQNext    = reqA[grantIdx];
          bQNext    = reqB[grantIdx];
          ptrNext   = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
          aDoneNext = 1'b0;
          bDoneNext = 1'b0;
          stateNext = ISSUE;
        end
      end

      ISSUE: begin
        // Valids are masked while reset is asserted so nothing leaks to the
        // adder during the reset cycle itself.
        inA_valid  = !aDoneReg && !rst_i;
        inB_valid  = !bDoneReg && !rst_i;
        aHandshake = inA_valid && inA_ready;
        bHandshake = inB_valid && inB_ready;
        if (aHandshake) begin
          aDoneNext = 1'b1;
        end
        if (bHandshake) begin
          bDoneNext = 1'b1;
        end
        if ((aDoneReg || aHandshake) && (bDoneReg || bHandshake)) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign inA = aQReg;
  assign inB = bQReg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg <= IDLE;
      ptrReg   <= '0;
      aQReg    <= '0;
      bQReg    <= '0;
      aDoneReg <= 1'b0;
      bDoneReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      ptrReg   <= ptrNext;
      aQReg    <= aQNext;
      bQReg    <= bQNext;
      aDoneReg <= aDoneNext;
      bDoneReg <= bDoneNext;
    end
  end

  // ---------------------------------------------------------------------
  // Response steering: the FIFO head names the owner of the adder's
  // current result. With nothing outstanding the result is not accepted.
  // ---------------------------------------------------------------------
  logic push, pop, rspActive, errSet;

  assign headId    = fifoMem[rdPtrReg];
  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == CNT_W'(TAG_DEPTH));
  assign push      = grant;
  assign rspActive = !fifoEmpty && !rst_i;

  always_comb begin
    rsp_valid_o = '0;
    out_ready   = 1'b0;
    if (rspActive) begin
      rsp_valid_o[headId] = out_valid;
      out_ready           = rsp_ready_i[headId];
    end
  end

  assign rsp_data_o = out;
  assign pop        = out_valid && out_ready;

  // A result with no outstanding pair (and none being accepted right now)
  // means the adder and this block disagree about what is in flight.
  assign errSet = out_valid && fifoEmpty && !push;

  // FIFO storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem[wrPtrReg] <= grantIdx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      errReg   <= 1'b0;
    end else begin
      if (push) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
      if (errSet) begin
        errReg <= 1'b1;
      end
    end
  end

  assign err_o = errReg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//
// Purpose:
//   Self-checking bench for adder_share_arbiter (DATA_IN_WIDTH=8, NUM_REQ=2,
//   TAG_DEPTH=4). A table of single-pair transactions, hand-written sequences
//   for fairness / FIFO full / skew / protocol error / mid-issue reset, and a
//   randomized run checked against a transaction-level reference model.
module tb_adder_share_arbiter;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int TD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*DW-1:0]  reqA, reqB;
  logic [NR-1:0]     reqValid, reqReady;
  logic [DW:0]       rspData;
  logic [NR-1:0]     rspValid, rspReady;
  logic [DW-1:0]     inA, inB;
  logic              inAValid, inBValid, inAReady, inBReady;
  logic [DW:0]       outData;
  logic              outValid, outReady;
  logic              errO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .DATA_IN_WIDTH(DW),
    .NUM_REQ(NR),
    .TAG_DEPTH(TD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_a_i(reqA),
    .req_b_i(reqB),
    .req_valid_i(reqValid),
    .req_ready_o(reqReady),
    .rsp_data_o(rspData),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .inA(inA),
    .inB(inB),
    .inA_valid(inAValid),
    .inB_valid(inBValid),
    .inA_ready(inAReady),
    .inB_ready(inBReady),
    .out(outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .err_o(errO)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int r);
    logic [NR-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
    reqA[r*DW +: DW] = a;
    reqB[r*DW +: DW] = b;
  endtask

  // Reset for two edges with requesters asserting, checking that nothing is
  // accepted or issued while reset is high, then idle outputs after release.
  task automatic doReset();
    rst      = 1'b1;
    reqValid = '1;
    reqA     = '0;
    reqB     = '0;
    rspReady = '0;
    inAReady = 1'b0;
    inBReady = 1'b0;
    outValid = 1'b0;
    outData  = '0;
    @(negedge clk);
    chk("rst_req_ready", reqReady, 0);
    chk("rst_in_valids", {inAValid, inBValid}, 0);
    nextCycle();
    reqValid = '0;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_valids", {inAValid, inBValid}, 0);
    chk("post_rst_out_ready", outReady, 0);
    chk("post_rst_rsp_valid", rspValid, 0);
    chk("post_rst_err", errO, 0);
    nextCycle();
  endtask

  // Table of single-pair transactions
  typedef struct {
    int            r;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   sum;
  } vecT;

  typedef struct {
    int            r;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pairT;

  vecT           vecs [6];
  logic [NR-1:0] fairExp [10];
  logic [NR-1:0] drainExp [4];
  logic [DW:0]   adderSum;

  // Reference model and adder model for the random run
  pairT          expQ [$];
  pairT          p;
  logic [DW-1:0] adA [$];
  logic [DW-1:0] adB [$];
  logic [DW:0]   adSum [$];
  int            mPtr, expG, lastGrant, head, nResp, cand;
  bit            mBusy, mADone, mBDone;
  logic [DW-1:0] mA, mB;

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h01, 9'h100};
    vecs[1] = '{1, 8'h80, 8'h80, 9'h100};
    vecs[2] = '{0, 8'h00, 8'h00, 9'h000};
    vecs[3] = '{1, 8'hFF, 8'hFF, 9'h1FE};
    vecs[4] = '{1, 8'h12, 8'h34, 9'h046};
    vecs[5] = '{0, 8'h7F, 8'h01, 9'h080};
    fairExp  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    drainExp = '{2'b10, 2'b01, 2'b10, 2'b01};

    // ---------------- table-driven single transactions ----------------
    doReset();
    for (int i = 0; i < 6; i++) begin
      reqA = '0;
      reqB = '0;
      setData(vecs[i].r, vecs[i].a, vecs[i].b);
      reqValid = oh(vecs[i].r);
      inAReady = 1'b1;
      inBReady = 1'b1;
      rspReady = '1;
      outValid = 1'b0;
      @(negedge clk);
      chk("vec_grant", reqReady, oh(vecs[i].r));
      nextCycle();
      reqValid = '0;
      @(negedge clk);
      chk("vec_in_valids", {inAValid, inBValid}, 2'b11);
      chk("vec_inA", inA, vecs[i].a);
      chk("vec_inB", inB, vecs[i].b);
      adderSum = {1'b0, inA} + {1'b0, inB};
      nextCycle();
      outData  = adderSum;
      outValid = 1'b1;
      @(negedge clk);
      chk("vec_rsp_valid", rspValid, oh(vecs[i].r));
      chk("vec_rsp_data", rspData, vecs[i].sum);
      chk("vec_out_ready", outReady, 1);
      chk("vec_in_valids_done", {inAValid, inBValid}, 2'b00);
      $display("vec %0d: r%0d %02h+%02h -> rsp_valid=%b data=%03h", i, vecs[i].r,
               vecs[i].a, vecs[i].b, rspValid, rspData);
      nextCycle();
      outValid = 1'b0;
    end

    // -------- fairness, FIFO full, drain order, protocol error --------
    doReset();
    setData(0, 8'h11, 8'h01);
    setData(1, 8'h22, 8'h02);
    reqValid = '1;
    inAReady = 1'b1;
    inBReady = 1'b1;
    rspReady = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("fair_grant", reqReady, fairExp[c]);
      $display("fair cycle %0d: req_ready=%b", c, reqReady);
      nextCycle();
    end
    outValid = 1'b1;
    outData  = 9'h033;
    rspReady = '1;
    @(negedge clk);
    chk("full_pop_rsp_valid", rspValid, 2'b01);
    chk("full_pop_no_grant", reqReady, 0);
    chk("full_pop_data", rspData, 9'h033);
    nextCycle();
    outValid = 1'b0;
    @(negedge clk);
    chk("full_resume_grant", reqReady, 2'b01);
    nextCycle();
    reqValid = '0;
    for (int k = 0; k < 4; k++) begin
      outValid = 1'b1;
      outData  = 9'h100 + 9'(k);
      @(negedge clk);
      chk("drain_rsp_valid", rspValid, drainExp[k]);
      chk("drain_out_ready", outReady, 1);
      $display("drain %0d: rsp_valid=%b data=%03h", k, rspValid, rspData);
      nextCycle();
    end
    outValid = 1'b1;
    @(negedge clk);
    chk("err_out_ready", outReady, 0);
    chk("err_rsp_valid", rspValid, 0);
    chk("err_not_yet", errO, 0);
    nextCycle();
    outValid = 1'b0;
    @(negedge clk);
    chk("err_set", errO, 1);
    nextCycle();
    @(negedge clk);
    chk("err_held", errO, 1);
    nextCycle();

    // ---------------- channel skew ----------------
    doReset();
    setData(0, 8'h0A, 8'h05);
    setData(1, 8'h33, 8'h44);
    reqValid = 2'b01;
    @(negedge clk);
    chk("skew_grant", reqReady, 2'b01);
    nextCycle();
    reqValid = '0;
    inAReady = 1'b1;
    @(negedge clk);
    chk("skew_c1_valids", {inAValid, inBValid}, 2'b11);
    chk("skew_c1_inA", inA, 8'h0A);
    nextCycle();
    @(negedge clk);
    chk("skew_c2_valids", {inAValid, inBValid}, 2'b01);
    chk("skew_c2_inB", inB, 8'h05);
    nextCycle();
    @(negedge clk);
    chk("skew_c3_valids", {inAValid, inBValid}, 2'b01);
    nextCycle();
    inBReady = 1'b1;
    reqValid = 2'b10;
    @(negedge clk);
    chk("skew_c4_inB_valid", inBValid, 1);
    chk("skew_c4_inB", inB, 8'h05);
    chk("skew_c4_no_grant", reqReady, 0);
    nextCycle();
    @(negedge clk);
    chk("skew_c5_inB_valid", inBValid, 0);
    chk("skew_c5_grant", reqReady, 2'b10);
    $display("skew: second grant at cycle 5 req_ready=%b", reqReady);
    nextCycle();
    reqValid = '0;

    // ---------------- reset mid-issue ----------------
    doReset();
    setData(0, 8'h01, 8'h02);
    setData(1, 8'h03, 8'h04);
    inAReady = 1'b1;
    inBReady = 1'b1;
    reqValid = 2'b10;
    @(negedge clk);
    chk("mid_rst_g1", reqReady, 2'b10);
    nextCycle();
    reqValid = '0;
    nextCycle();
    reqValid = 2'b01;
    @(negedge clk);
    chk("mid_rst_g2", reqReady, 2'b01);
    nextCycle();
    reqValid = '0;
    inAReady = 1'b0;
    inBReady = 1'b0;
    @(negedge clk);
    chk("mid_rst_issuing", {inAValid, inBValid}, 2'b11);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_during_valids", {inAValid, inBValid}, 2'b00);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_after_valids", {inAValid, inBValid}, 2'b00);
    chk("mid_rst_after_ready", reqReady, 0);
    chk("mid_rst_after_rsp", rspValid, 0);
    chk("mid_rst_after_err", errO, 0);
    nextCycle();
    reqValid = '1;
    inAReady = 1'b1;
    inBReady = 1'b1;
    rspReady = '1;
    @(negedge clk);
    chk("mid_rst_first_r0", reqReady, 2'b01);
    nextCycle();
    reqValid = '0;
    outValid = 1'b1;
    outData  = 9'h003;
    @(negedge clk);
    chk("mid_rst_head_r0", rspValid, 2'b01);
    nextCycle();
    @(negedge clk);
    chk("mid_rst_fifo_empty", {outReady, rspValid}, 0);
    nextCycle();
    outValid = 1'b0;
    @(negedge clk);
    chk("mid_rst_err", errO, 1);
    nextCycle();

    // ---------------- randomized run against reference model ----------------
    doReset();
    expQ.delete();
    adA.delete();
    adB.delete();
    adSum.delete();
    mPtr      = 0;
    mBusy     = 1'b0;
    mADone    = 1'b0;
    mBDone    = 1'b0;
    mA        = '0;
    mB        = '0;
    lastGrant = -1;
    nResp     = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // drive (just after the rising edge)
      if (lastGrant >= 0) begin
        reqValid[lastGrant] = 1'b0;
      end
      lastGrant = -1;
      for (int r = 0; r < NR; r++) begin
        if (!reqValid[r] && ($urandom_range(0, 2) == 0)) begin
          reqValid[r] = 1'b1;
          setData(r, DW'($urandom), DW'($urandom));
        end
      end
      for (int r = 0; r < NR; r++) begin
        rspReady[r] = ($urandom_range(0, 3) != 0);
      end
      inAReady = ($urandom_range(0, 2) != 0);
      inBReady = ($urandom_range(0, 2) != 0);
      outValid = (adSum.size() > 0) && ($urandom_range(0, 3) != 0);
      outData  = (adSum.size() > 0) ? adSum[0] : '0;

      @(negedge clk);
      // expected grant: first valid requester at/after the pointer
      expG = -1;
      if (!mBusy && (expQ.size() < TD)) begin
        for (int k = 0; k < NR; k++) begin
          cand = (mPtr + k) % NR;
          if ((expG < 0) && reqValid[cand]) begin
            expG = cand;
          end
        end
      end
      chk("rnd_grant", reqReady, (expG >= 0) ? oh(expG) : '0);
      chk("rnd_inA_valid", inAValid, mBusy && !mADone);
      chk("rnd_inB_valid", inBValid, mBusy && !mBDone);
      if (mBusy && !mADone) begin
        chk("rnd_inA", inA, mA);
      end
      if (mBusy && !mBDone) begin
        chk("rnd_inB", inB, mB);
      end
      if (expQ.size() > 0) begin
        head = expQ[0].r;
        chk("rnd_rsp_valid", rspValid, outValid ? oh(head) : '0);
        chk("rnd_out_ready", outReady, rspReady[head]);
        if (outValid && rspReady[head]) begin
          chk("rnd_rsp_data", rspData, {1'b0, expQ[0].a} + {1'b0, expQ[0].b});
          $display("rnd rsp r%0d %02h+%02h data=%03h", head, expQ[0].a, expQ[0].b, rspData);
          void'(expQ.pop_front());
          nResp++;
        end
      end else begin
        chk("rnd_rsp_valid_empty", rspValid, 0);
        chk("rnd_out_ready_empty", outReady, 0);
      end

      // adder model reacts to what the DUT actually presented
      if (inAValid && inAReady) begin
        adA.push_back(inA);
      end
      if (inBValid && inBReady) begin
        adB.push_back(inB);
      end
      if (outValid && outReady && (adSum.size() > 0)) begin
        void'(adSum.pop_front());
      end
      while ((adA.size() > 0) && (adB.size() > 0)) begin
        adSum.push_back({1'b0, adA[0]} + {1'b0, adB[0]});
        void'(adA.pop_front());
        void'(adB.pop_front());
      end

      // reference model advance
      if (mBusy) begin
        if (!mADone && inAReady) begin
          mADone = 1'b1;
        end
        if (!mBDone && inBReady) begin
          mBDone = 1'b1;
        end
        if (mADone && mBDone) begin
          mBusy = 1'b0;
        end
      end
      if (expG >= 0) begin
        p.r = expG;
        p.a = reqA[expG*DW +: DW];
        p.b = reqB[expG*DW +: DW];
        expQ.push_back(p);
        mA        = p.a;
        mB        = p.b;
        mBusy     = 1'b1;
        mADone    = 1'b0;
        mBDone    = 1'b0;
        mPtr      = (expG + 1) % NR;
        lastGrant = expG;
      end
      nextCycle();
    end
    chk("rnd_no_err", errO, 0);
    chk("rnd_progress", (nResp > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
